// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

    localparam int unsigned AES_BLK   = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  GF_POLY   = 8'h1b;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle of the iterative AES core.
interface aes_iter_core_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [AES_BLK-1:0] key;
    logic [AES_BLK-1:0] din;
    logic               out_valid;
    logic               out_ready;
    logic [AES_BLK-1:0] dout;

    modport master (
        output in_valid, key, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, key, din, out_ready,
        output in_ready, out_valid, dout
    );

endinterface

// File: rtl/aes_round_step.sv
// One combinational AES-128 round plus the matching round-key expansion step.
module aes_round_step
    import aes_pkg::*;
(
    input  logic [AES_BLK-1:0] st,
    input  logic [AES_BLK-1:0] rk,
    input  logic [7:0]         rcon,
    input  logic               last,
    output logic [AES_BLK-1:0] st_next,
    output logic [AES_BLK-1:0] rk_next
);
    // Byte i is st[127-8*i -: 8]; column c holds bytes 4c..4c+3 (rows 0..3).
    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [7:0]  kw [4];
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(st[AES_BLK-1-8*i -: 8]), .y(sb[i]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        // ShiftRows: row r of column c comes from column (c + r) mod 4
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        assign mc[4*c+0] = gmul2(sr[4*c+0]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
        assign mc[4*c+3] = gmul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
    end

    assign {w0, w1, w2, w3} = rk;

    // SubWord(RotWord(w3)): output byte j is the S-box of w3 byte (j+1) mod 4
    for (genvar j = 0; j < 4; j++) begin : g_key
        aes_sbox u_sbox (.a(w3[31-8*((j+1)%4) -: 8]), .y(kw[j]));
    end

    assign n0 = w0 ^ {kw[0] ^ rcon, kw[1], kw[2], kw[3]};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign st_next[AES_BLK-1-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk_next[AES_BLK-1-8*i -: 8];
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule,
// valid/ready in and out, reduced-round support via NR.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned NR        = 10,
    parameter int unsigned FINAL_MIX = 0
) (
    input  logic            clk,
    input  logic            rst,
    aes_iter_core_if.slave  bus,
    output logic            busy,
    output logic [3:0]      round_cnt
);
    if (NR < 1 || NR > 10) begin : g_nr_check
        $error("aes_iter_core: NR must be within 1..10");
    end

    fsm_e               fsm_q;
    logic [AES_BLK-1:0] st_q;
    logic [AES_BLK-1:0] rk_q;
    logic [7:0]         rcon_q;
    logic [AES_BLK-1:0] st_next;
    logic [AES_BLK-1:0] rk_next;
    logic               accept;
    logic               final_rnd;
    logic               last;

    // Combinational ready lets a new block enter the cycle the old one drains.
    assign bus.in_ready = (fsm_q == IDLE) | ((fsm_q == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign final_rnd    = (round_cnt == 4'(NR));
    assign last         = final_rnd & (FINAL_MIX == 0);

    aes_round_step u_step (
        .st      (st_q),
        .rk      (rk_q),
        .rcon    (rcon_q),
        .last    (last),
        .st_next (st_next),
        .rk_next (rk_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.dout      <= '0;
            busy          <= 1'b0;
            round_cnt     <= 4'd0;
            rcon_q        <= RCON_INIT;
        end else if (accept) begin
            st_q          <= bus.din ^ bus.key;
            rk_q          <= bus.key;
            rcon_q        <= RCON_INIT;
            round_cnt     <= 4'd1;
            fsm_q         <= RUN;
            busy          <= 1'b1;
            bus.out_valid <= 1'b0;
        end else if (fsm_q == RUN) begin
            st_q   <= st_next;
            rk_q   <= rk_next;
            rcon_q <= xtime(rcon_q);
            if (final_rnd) begin
                fsm_q         <= DONE;
                bus.dout      <= st_next;
                bus.out_valid <= 1'b1;
                busy          <= 1'b0;
                round_cnt     <= 4'd0;
            end else begin
                round_cnt <= round_cnt + 4'd1;
            end
        end else if (fsm_q == DONE && bus.out_ready) begin
            fsm_q         <= IDLE;
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES-128 encryption core with a valid/ready handshake. It computes one round per clock and expands round keys on the fly. The round count is parametrised so the same RTL serves full-strength encryption (NR=10) and reduced-round variants for the team's round-reduced cipher experiments. It is a resource-light successor to the team's fully unrolled, free-running round chains: it adds flow control, a run/done state machine, reset and a configurable final-round mode.

Parameters:
NR, 10, number of rounds, legal range 1..10; elaboration error outside that range
FINAL_MIX, 0, 0 = last round omits MixColumns (FIPS-197); 1 = every round includes MixColumns

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  din/key offered
in_ready  out  1  core can accept a block
key  in  128  cipher key, sampled on accept only
din  in  128  plaintext, sampled on accept only
out_valid  out  1  dout holds a finished ciphertext
out_ready  in  1  consumer takes dout
dout  out  128  ciphertext, stable while out_valid=1
busy  out  1  high in RUN
round_cnt  out  4  current round index; 0 when not in RUN

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-RUN: state to IDLE, out_valid=0, dout=0, busy=0, round_cnt=0, rcon=8'h01. Any in-flight block is discarded.
- in_ready = (fsm==IDLE) | (fsm==DONE & out_ready). This is combinational, and allows back-to-back blocks with zero bubble.
- accept = in_valid & in_ready. On accept:
  - st <= din ^ key
  - rk <= key
  - rcon <= 8'h01
  - round_cnt <= 1
  - fsm <= RUN
- RUN, at each edge:
  - rk_n = expand(rk, rcon), using the standard AES-128 schedule with RotWord, SubWord and rcon on word 0
  - st <= round(st, rk_n, last), where last = (round_cnt==NR) & (FINAL_MIX==0)
  - rk <= rk_n
  - rcon <= xtime(rcon), with GF(2^8) reduction 0x1b, so 0x80 becomes 0x1b
  - If round_cnt==NR: fsm <= DONE and the final st is loaded into dout. Otherwise round_cnt increments.
- Latency: with accept at edge t, out_valid is high from edge t+NR onward. Throughput is one block per NR+1 cycles with out_ready held high.
- DONE: out_valid=1 and dout is held until out_ready=1.
  - out_ready=1 and accept in the same cycle: go straight to RUN with the new block; out_valid falls.
  - out_ready=1 without accept: go to IDLE and clear out_valid. dout keeps its value, but it is a don't-care once out_valid=0.
- in_valid while busy: ignored; in_ready=0 and no state change.
- NR=1 with FINAL_MIX=0: a single final-form round.
- round_cnt never exceeds NR.

Decomposition:
- Package aes_pkg holds:
  - fsm enum {IDLE, RUN, DONE}
  - AES_BLK=128, RCON_INIT=8'h01, GF_POLY=8'h1b
  - functions xtime and gmul2/gmul3
- One sub-module, aes_round_step, is purely combinational.
  - Inputs: st, rk, rcon, last.
  - Outputs: st_next, rk_next.
  - Contents: SubBytes, ShiftRows, MixColumns (bypassed when last), AddRoundKey, and the key expansion.
  - It reuses the team's existing S-box table module.
- aes_iter_core holds only the FSM, the registers and the handshake.

Test Plan:
1. NR=10, FINAL_MIX=0, key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff, out_ready=1 -> dout=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after the accept edge and is high for 1 cycle.
2. Key 2b7e151628aed2a6abf7158809cf4f3c, din 3243f6a8885a308d313198a2e0370734, out_ready held 0 for 5 cycles after done -> dout=3925841d02dc09fbdc118597196a0b32 held stable with out_valid=1 throughout; in_ready=0 until out_ready rises.
3. Back-to-back: in_valid held with the two vectors above, out_ready=1 -> results in order with a period of 11 cycles; the second accept coincides with the first out_valid cycle.
4. rst asserted at round_cnt=5 -> next cycle: IDLE, out_valid=0, busy=0, round_cnt=0; the following block (vector 1) still yields 69c4e0d8...c55a.
5. NR=4 and NR=1, both FINAL_MIX settings, 1000 random key/din pairs -> dout matches the C reference model (reduced-round AES); round_cnt sequence is 1..NR; in_valid pulses during RUN are ignored.
